// File: rtl/muldiv_pkg.sv
// Shared RV32M multiply/divide definitions: funct3 op encodings and a
// conditional two's-complement helper used during operand preparation.
package muldiv_pkg;

  localparam logic [2:0] MD_OP_MUL    = 3'b000;
  localparam logic [2:0] MD_OP_MULH   = 3'b001;
  localparam logic [2:0] MD_OP_MULHSU = 3'b010;
  localparam logic [2:0] MD_OP_MULHU  = 3'b011;
  localparam logic [2:0] MD_OP_DIV    = 3'b100;
  localparam logic [2:0] MD_OP_DIVU   = 3'b101;
  localparam logic [2:0] MD_OP_REM    = 3'b110;
  localparam logic [2:0] MD_OP_REMU   = 3'b111;

  function automatic logic [31:0] cond_neg32(input logic [31:0] value, input logic en);
    return en ? (~value + 32'd1) : value;
  endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Conditional 64-bit two's complement, used for the final sign fixup of
// products, quotients and remainders.
module muldiv_negate (
  input  logic [63:0] value_i,
  input  logic        neg_i,
  output logic [63:0] value_o
);

  assign value_o = neg_i ? (~value_i + 64'd1) : value_i;

endmodule

// File: rtl/muldiv.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply and
// restoring divide sharing one datapath, behind a valid/ready handshake.
module muldiv
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        kill,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  output logic        done,
  output logic [31:0] out
);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_e;

  state_e      state_q, state_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] dvs_q, dvs_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic        neg_q, neg_d;
  logic [31:0] out_q, out_d;

  logic        accept;
  logic        a_signed, b_signed, sa, sb;
  logic [31:0] mag_a, mag_b;
  logic        is_special;
  logic [31:0] special_val;
  logic [32:0] mul_sum, div_trial, div_diff;
  logic [63:0] iter_next, fix_in, fix_out;
  logic [31:0] final_val;

  assign accept  = valid_i && (state_q == IDLE) && !kill;
  assign ready_o = (state_q == IDLE);
  assign done    = (state_q == FIN);
  assign out     = out_q;

  // Operand prep: magnitudes of signed operands and early-out special cases
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (op)
      MD_OP_MULH, MD_OP_DIV, MD_OP_REM: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      MD_OP_MULHSU: a_signed = 1'b1;
      default: ;
    endcase
    sa    = a_signed & a[31];
    sb    = b_signed & b[31];
    mag_a = cond_neg32(a, sa);
    mag_b = cond_neg32(b, sb);

    is_special  = 1'b0;
    special_val = 32'd0;
    if (op[2] && (b == 32'd0)) begin
      is_special  = 1'b1;
      special_val = op[1] ? a : 32'hFFFF_FFFF;
    end else if (((op == MD_OP_DIV) || (op == MD_OP_REM)) &&
                 (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
      is_special  = 1'b1;
      special_val = op[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  // One iteration: divide keeps {rem, quot} in acc, multiply keeps {hi, multiplier}
  always_comb begin
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, dvs_q} : 33'd0);
    div_trial = {acc_q[63:32], acc_q[31]};
    div_diff  = div_trial - {1'b0, dvs_q};
    if (op_q[2]) begin
      iter_next = div_diff[32] ? {div_trial[31:0], acc_q[30:0], 1'b0}
                               : {div_diff[31:0], acc_q[30:0], 1'b1};
    end else begin
      iter_next = {mul_sum, acc_q[31:1]};
    end

    case (op_q)
      MD_OP_DIV, MD_OP_DIVU: fix_in = {32'd0, iter_next[31:0]};
      MD_OP_REM, MD_OP_REMU: fix_in = {32'd0, iter_next[63:32]};
      default:               fix_in = iter_next;
    endcase
  end

  muldiv_negate u_negate (
    .value_i (fix_in),
    .neg_i   (neg_q),
    .value_o (fix_out)
  );

  always_comb begin
    case (op_q)
      MD_OP_MULH, MD_OP_MULHSU, MD_OP_MULHU: final_val = fix_out[63:32];
      default:                               final_val = fix_out[31:0];
    endcase
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_d   = neg_q;
    out_d   = out_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d  = op;
          cnt_d = 5'd0;
          neg_d = (op[2] && op[1]) ? sa : (sa ^ sb);
          if (op[2]) begin
            acc_d = {32'd0, mag_a};
            dvs_d = mag_b;
          end else begin
            acc_d = {32'd0, mag_b};
            dvs_d = mag_a;
          end
          if (is_special) begin
            out_d   = special_val;
            state_d = FIN;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        acc_d = iter_next;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          out_d   = final_val;
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A flush abandons the op without touching the visible result
    if (kill) begin
      state_d = IDLE;
      cnt_d   = 5'd0;
      out_d   = out_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= 64'd0;
      dvs_q   <= 32'd0;
      cnt_q   <= 5'd0;
      op_q    <= MD_OP_MUL;
      neg_q   <= 1'b0;
      out_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      out_q   <= out_d;
    end
  end

endmodule

// File: tb/tb_muldiv.sv
// Scoreboard bench for muldiv: directed RV32M vectors, kill and async reset
// scenarios, then a randomized run against a behavioural reference model.
module tb_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic        ready_o;
  logic        kill;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  op;
  logic        done;
  logic [31:0] out;

  int assertCount = 0;
  int failCount   = 0;
  int cycleCount  = 0;

  typedef struct {
    string       name;
    logic [31:0] value;
    int          lat;
    int          acceptCycle;
  } sbEntry_t;

  sbEntry_t sbQueue[$];

  muldiv dut (
    .clk     (clk),
    .rst     (rst),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .kill    (kill),
    .a       (a),
    .b       (b),
    .op      (op),
    .done    (done),
    .out     (out)
  );

  // Free-running clock and a cycle counter used for latency measurement
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Compare one observed value against the expected one and count the result
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Behavioural RV32M reference built on the simulator's own arithmetic
  function automatic logic [31:0] refModel(input logic [2:0] rOp, input logic [31:0] ra, input logic [31:0] rb);
    logic [63:0] sA, sB, uA, uB, prod;
    logic        ovf;
    sA  = {{32{ra[31]}}, ra};
    sB  = {{32{rb[31]}}, rb};
    uA  = {32'd0, ra};
    uB  = {32'd0, rb};
    ovf = (ra == 32'h8000_0000) && (rb == 32'hFFFF_FFFF);
    case (rOp)
      3'd0: begin prod = uA * uB; return prod[31:0];  end
      3'd1: begin prod = sA * sB; return prod[63:32]; end
      3'd2: begin prod = sA * uB; return prod[63:32]; end
      3'd3: begin prod = uA * uB; return prod[63:32]; end
      3'd4: return (rb == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(ra) / $signed(rb));
      3'd5: return (rb == 0) ? 32'hFFFF_FFFF : ra / rb;
      3'd6: return (rb == 0) ? ra : ovf ? 32'd0 : 32'($signed(ra) % $signed(rb));
      default: return (rb == 0) ? ra : ra % rb;
    endcase
  endfunction

  // Issue one request once the unit is ready; optionally register the expectation
  task automatic applyStimulus(input logic [2:0] opIn, input logic [31:0] aIn, input logic [31:0] bIn,
                               input bit track, input logic [31:0] expVal, input int expLat,
                               input string name);
    int waitCycles = 0;
    @(negedge clk);
    while (!ready_o && waitCycles < 200) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!ready_o) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL %s_ready_timeout: ready_o=%0b after %0d cycles, expected 1", name, ready_o, waitCycles);
      return;
    end
    op      = opIn;
    a       = aIn;
    b       = bIn;
    valid_i = 1'b1;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    a       = $urandom;
    b       = $urandom;
    op      = 3'($urandom_range(0, 7));
    if (track) sbQueue.push_back('{name, expVal, expLat, cycleCount});
  endtask

  // Wait (bounded) until every expected result has been observed
  task automatic waitDrain();
    int waitCycles = 0;
    while (sbQueue.size() != 0 && waitCycles < 200) begin
      @(negedge clk);
      waitCycles++;
    end
    if (sbQueue.size() != 0) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL drain_timeout: %0d results outstanding, expected 0", sbQueue.size());
      sbQueue.delete();
    end
    @(negedge clk);
  endtask

  // Monitor: every done pulse is matched against the scoreboard head
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sbQueue.size() == 0) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL unexpected_done: done=1 out=0x%08h, expected no done", out);
      end else begin
        sbEntry_t e;
        e = sbQueue.pop_front();
        checkOutput(e.name, out, e.value);
        if (e.lat != 0) checkOutput({e.name, "_latency"}, 32'(cycleCount - e.acceptCycle + 1), 32'(e.lat));
      end
    end
  end

  // Hard ceiling on simulated time so the run always ends
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst     = 1'b1;
    valid_i = 1'b0;
    kill    = 1'b0;
    a       = 32'd0;
    b       = 32'd0;
    op      = 3'd0;

    #12;
    checkOutput("reset_ready", 32'(ready_o), 32'd1);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_out", out, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] directed vectors");
    applyStimulus(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 1, 32'hFFFF_FFEB, 33, "mul_7_m3");
    applyStimulus(3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0000_0000, 33, "mulh");
    applyStimulus(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 33, "mulhsu");
    applyStimulus(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h7FFF_FFFF, 33, "mulhu");
    applyStimulus(3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 1, 32'hFFFF_FFFD, 33, "div_m7_2");
    applyStimulus(3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 1, 32'hFFFF_FFFF, 33, "rem_m7_2");
    applyStimulus(3'd5, 32'd100, 32'd7, 1, 32'd14, 33, "divu_100_7");
    applyStimulus(3'd7, 32'd100, 32'd7, 1, 32'd2, 33, "remu_100_7");
    applyStimulus(3'd4, 32'h1234_5678, 32'd0, 1, 32'hFFFF_FFFF, 1, "div_by_zero");
    applyStimulus(3'd6, 32'h1234_5678, 32'd0, 1, 32'h1234_5678, 1, "rem_by_zero");
    applyStimulus(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 1, "div_overflow");
    applyStimulus(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0000_0000, 1, "rem_overflow");
    applyStimulus(3'd7, 32'd100, 32'd7, 1, 32'd2, 33, "remu_before_kill");
    waitDrain();

    $display("[TB] kill during CALC");
    applyStimulus(3'd0, 32'd5, 32'd6, 0, 32'd0, 0, "killed_mul");
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    checkOutput("kill_ready", 32'(ready_o), 32'd1);
    checkOutput("kill_done", 32'(done), 32'd0);
    checkOutput("kill_out_held", out, 32'd2);
    applyStimulus(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 33, "mulhu_after_kill");
    waitDrain();

    $display("[TB] async reset during CALC");
    applyStimulus(3'd5, 32'd1000, 32'd3, 0, 32'd0, 0, "reset_divu");
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midcalc_reset_ready", 32'(ready_o), 32'd1);
    checkOutput("midcalc_reset_done", 32'(done), 32'd0);
    checkOutput("midcalc_reset_out", out, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] random regression");
    for (int i = 0; i < 1000; i++) begin
      logic [2:0]  rOp;
      logic [31:0] rA, rB;
      int          rLat;
      int          sel;
      rOp = 3'($urandom_range(0, 7));
      rA  = $urandom;
      rB  = $urandom;
      sel = $urandom_range(0, 31);
      if (sel == 0) rB = 32'd0;
      else if (sel == 1) begin
        rA = 32'h8000_0000;
        rB = 32'hFFFF_FFFF;
      end else if (sel < 6) begin
        rA = 32'($urandom_range(0, 200)) - 32'd100;
        rB = 32'($urandom_range(1, 20));
      end
      rLat = (rOp[2] && ((rB == 32'd0) || (!rOp[0] && rA == 32'h8000_0000 && rB == 32'hFFFF_FFFF))) ? 1 : 33;
      applyStimulus(rOp, rA, rB, 1, refModel(rOp, rA, rB), rLat, "random");
    end
    waitDrain();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
